fp_accum_seq: RTL and testbench
===============================

Name: fp_accum_seq

Overview:
- Sequencer that reduces a stream of N IEEE-754 single-precision operands to one sum using a shared external 4-input FP adder.
- Each pass feeds the running accumulator plus up to 3 new operands into the adder and captures the adder result as the new accumulator.
- Sits between an operand stream (valid/ready) and a result consumer (valid/ready); the adder itself is instantiated outside this block.

Parameters:
LEN_W, 16, width of the vector-length command.
ADDER_LAT, 0, register stages inside the external adder path. 0 means the adder is purely combinational.
PAD, 32'h0000_0000, value driven on unused adder lanes and used as the initial accumulator.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle command pulse; accepted only in IDLE.
len  input  LEN_W  operand count N; sampled with start.
busy  output  1  high in every state except IDLE.
in_valid  input  1  operand valid.
in_data  input  32  operand.
in_ready  output  1  high only in COLLECT.
add_in0  output  32  adder lane 0 (accumulator).
add_in1  output  32  adder lane 1.
add_in2  output  32  adder lane 2.
add_in3  output  32  adder lane 3.
add_out  input  32  adder result.
res_valid  output  1  final sum valid.
res_data  output  32  final sum.
res_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE; busy, in_ready and res_valid = 0;
  - res_data, add_in0..3, accumulator, lane registers and counters = 0.
- FSM states: IDLE, COLLECT, ADD, DONE.
- IDLE:
  - start=1 with len>0: load remaining=len, acc=PAD, lane_cnt=0; go to COLLECT.
  - start=1 with len=0: acc=PAD; go to DONE.
  - start=0: stay in IDLE.
- COLLECT:
  - in_ready=1. Each handshake (in_valid and in_ready) writes in_data to lane[lane_cnt+1], increments lane_cnt, decrements remaining.
  - When an accept makes lane_cnt=3 or remaining=0: fill every unwritten lane with PAD, drive add_in0=acc and add_in1..3=lanes (registered), go to ADD next cycle.
  - in_valid=0 stalls without state change.
- ADD:
  - in_ready=0; add_in0..3 held stable for the whole state.
  - Lasts exactly ADDER_LAT+1 cycles (wait counter). On the final cycle's edge acc<=add_out.
  - Then: remaining=0 goes to DONE; otherwise clear lane_cnt and go to COLLECT.
- DONE:
  - res_valid=1, res_data=acc. res_data is updated on DONE entry and stable while res_valid=1.
  - Leave to IDLE on res_ready=1. res_valid drops the following cycle.
- start is ignored when busy=1 (no effect on len or state). res_ready outside DONE is ignored.
- Timing:
  - Pass count = ceil(N/3).
  - With in_valid held at 1, each full pass takes 3 COLLECT cycles + (ADDER_LAT+1) ADD cycles.
  - N=1..3 with no stalls: res_valid asserts N+ADDER_LAT+2 cycles after the start cycle.
- PAD is nonzero in the adder's arithmetic (the adder applies an implicit leading one, so 0x0 reads as 2^-127). It is shifted out whenever any real operand has exponent ≥ 24. The block does not correct this.
- len counter arithmetic is unsigned LEN_W. Maximum N = 2^LEN_W-1; no wrap occurs because remaining only decrements to 0.
- Reset asserted mid-operation: returns to IDLE immediately, with no result and no partial handshake retained.

Test Plan:
- The bench uses a behavioural model of the 4-input adder (ADDER_LAT=0 and 2 variants).
- start, len=3; in_data 0x3F800000 x3 back-to-back → one ADD pass, res_data=0x40400000 (3.0), res_valid 5 cycles after start (ADDER_LAT=0).
- len=4, four 1.0 operands → two passes (second pass with lanes 2,3 = PAD), res_data=0x40800000 (4.0). With ADDER_LAT=2, each ADD lasts 3 cycles.
- len=2: 0x40000000 (2.0), 0xBF000000 (-0.5) → res_data=0x3FC00000 (1.5).
- len=0 → DONE the next cycle with res_data=0x00000000, no in_ready assertion; hold res_ready=0 for 5 cycles → res_valid and res_data stable, and a start pulse in that window is ignored.
- len=6 with in_valid toggled every other cycle → in_ready stays 1 throughout COLLECT, exactly 6 handshakes, result 6.0 (0x40C00000).
- Drop rst_n during the second ADD of a len=6 run → all outputs 0 asynchronously; a fresh len=3 run afterwards gives 3.0.

Source files
------------

// File: rtl/fp_accum_seq.sv
// rtl/fp_accum_seq.sv - sequencer reducing N FP32 operands through a shared external 4-input adder
module fp_accum_seq #(
  parameter int          LEN_W     = 16,
  parameter int          ADDER_LAT = 0,
  parameter logic [31:0] PAD       = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      add_in0,
  output logic [31:0]      add_in1,
  output logic [31:0]      add_in2,
  output logic [31:0]      add_in3,
  input  logic [31:0]      add_out,
  output logic             res_valid,
  output logic [31:0]      res_data,
  input  logic             res_ready
);

  localparam int WW = $clog2(ADDER_LAT + 2);

  typedef enum logic [1:0] {IDLE, COLLECT, ADD, DONE} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       lane_cnt;
  logic [31:0]      acc;
  logic [31:0]      lane    [1:3];
  logic [31:0]      lane_nx [1:3];
  logic [WW-1:0]    wait_cnt;
  logic             accept, last_accept, add_last;

  assign accept      = (state == COLLECT) && in_valid;
  assign last_accept = accept && ((lane_cnt == 2'd2) || (remaining == LEN_W'(1)));
  assign add_last    = (state == ADD) && (wait_cnt == WW'(ADDER_LAT));

  // Lane image after the current accept: new operand in its slot, older slots
  // kept, not-yet-written slots padded so a short final pass is well defined.
  always_comb begin
    for (int i = 1; i <= 3; i++) begin
      lane_nx[i] = PAD;
      if (i == int'(lane_cnt) + 1)
        lane_nx[i] = in_data;
      else if (i <= int'(lane_cnt))
        lane_nx[i] = lane[i];
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    in_ready  = (state == COLLECT);
    res_valid = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = (len != '0) ? COLLECT : DONE;
      COLLECT: if (last_accept) state_nx = ADD;
      ADD:     if (add_last) state_nx = (remaining == '0) ? DONE : COLLECT;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      lane_cnt  <= '0;
      acc       <= '0;
      wait_cnt  <= '0;
      add_in0   <= '0;
      add_in1   <= '0;
      add_in2   <= '0;
      add_in3   <= '0;
      res_data  <= '0;
      for (int i = 1; i <= 3; i++) lane[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= PAD;
            remaining <= len;
            lane_cnt  <= '0;
            if (len == '0) res_data <= PAD;
          end
        end
        COLLECT: begin
          if (accept) begin
            for (int i = 1; i <= 3; i++) lane[i] <= lane_nx[i];
            lane_cnt  <= lane_cnt + 2'd1;
            remaining <= remaining - LEN_W'(1);
            if (last_accept) begin
              add_in0  <= acc;
              add_in1  <= lane_nx[1];
              add_in2  <= lane_nx[2];
              add_in3  <= lane_nx[3];
              wait_cnt <= '0;
            end
          end
        end
        ADD: begin
          // Adder inputs stay frozen; the result is taken once the pipeline has drained.
          if (add_last) begin
            acc <= add_out;
            if (remaining == '0) res_data <= add_out;
            else lane_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// tb/tb_fp_accum_seq.sv - bench for fp_accum_seq with combinational and 2-stage adder models
module tb_fp_accum_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        start, in_valid, res_ready;
  logic [1:0][15:0]  len;
  logic [1:0][31:0]  in_data;
  wire  [1:0]        busy, in_ready, res_valid;
  wire  [1:0][31:0]  add_in0, add_in1, add_in2, add_in3, res_data;
  logic [31:0]       add_out_c, add_out_p, pipe1, pipe2;

  logic [31:0] ops[$];
  int checks = 0;
  int errors = 0;

  fp_accum_seq #(.LEN_W(16), .ADDER_LAT(0), .PAD(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .len(len[0]), .busy(busy[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .add_in0(add_in0[0]), .add_in1(add_in1[0]), .add_in2(add_in2[0]), .add_in3(add_in3[0]),
    .add_out(add_out_c), .res_valid(res_valid[0]), .res_data(res_data[0]), .res_ready(res_ready[0]));

  fp_accum_seq #(.LEN_W(16), .ADDER_LAT(2), .PAD(32'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .len(len[1]), .busy(busy[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .add_in0(add_in0[1]), .add_in1(add_in1[1]), .add_in2(add_in2[1]), .add_in3(add_in3[1]),
    .add_out(add_out_p), .res_valid(res_valid[1]), .res_data(res_data[1]), .res_ready(res_ready[1]));

  // Adder arithmetic with an implicit leading one on every lane, so 0x0 reads as 2^-127.
  function automatic real f_dec(input logic [31:0] b);
    real v;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] f_enc(input real x);
    logic s;
    int   e;
    real  m;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  always @* add_out_c = f_enc(f_dec(add_in0[0]) + f_dec(add_in1[0]) + f_dec(add_in2[0]) + f_dec(add_in3[0]));
  always @(posedge clk) begin
    pipe1 <= f_enc(f_dec(add_in0[1]) + f_dec(add_in1[1]) + f_dec(add_in2[1]) + f_dec(add_in3[1]));
    pipe2 <= pipe1;
  end
  assign add_out_p = pipe2;

  function automatic int exp_lat(input int d, input int n);
    return ((n + 2) / 3) * ((d == 0 ? 0 : 2) + 1) + n + 1;
  endfunction

  // Drives one command and the operands in ops; returns what it observed, compares nothing.
  task automatic do_run(input int d, input int n, input bit toggle, output logic [31:0] res,
                        output int lat, output int hs, output int rdy_cyc, output bit timeout);
    int idx;
    idx = 0; hs = 0; rdy_cyc = 0;
    start[d] = 1'b1; len[d] = n[15:0]; in_valid[d] = 1'b0;
    @(posedge clk); #1;
    start[d] = 1'b0;
    lat = 1;
    while (!res_valid[d] && lat < 300) begin
      in_valid[d] = (idx < n) && (!toggle || (lat % 2) == 1);
      in_data[d]  = (idx < n) ? ops[idx] : $urandom;
      if (in_ready[d]) rdy_cyc++;
      if (in_ready[d] && in_valid[d]) begin hs++; idx++; end
      @(posedge clk); #1;
      lat++;
    end
    in_valid[d] = 1'b0;
    timeout = !res_valid[d];
    res = res_data[d];
  endtask

  task automatic ack(input int d, output logic v_after);
    res_ready[d] = 1'b1;
    @(posedge clk); #1;
    res_ready[d] = 1'b0;
    v_after = res_valid[d];
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d%0d got %b want 0", d, busy[d]); end
      checks++; if (in_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready d%0d got %b want 0", d, in_ready[d]); end
      checks++; if (res_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_res_valid d%0d got %b want 0", d, res_valid[d]); end
      checks++; if (res_data[d] !== 32'h0) begin errors++; $display("FAIL reset_res_data d%0d got %h want 0", d, res_data[d]); end
      checks++;
      if ({add_in0[d], add_in1[d], add_in2[d], add_in3[d]} !== 128'h0) begin
        errors++; $display("FAIL reset_add_in d%0d got %h %h %h %h want 0", d, add_in0[d], add_in1[d], add_in2[d], add_in3[d]);
      end
    end
  endtask

  task automatic test_vector(input int d, input string nm, input logic [31:0] want);
    logic [31:0] res; int lat, hs, rc; bit to; logic v;
    do_run(d, ops.size(), 1'b0, res, lat, hs, rc, to);
    checks++; if (to) begin errors++; $display("FAIL %s_timeout d%0d no res_valid", nm, d); end
    checks++; if (res !== want) begin errors++; $display("FAIL %s_res d%0d got %h want %h", nm, d, res, want); end
    checks++; if (lat !== exp_lat(d, ops.size())) begin errors++; $display("FAIL %s_lat d%0d got %0d want %0d", nm, d, lat, exp_lat(d, ops.size())); end
    checks++; if (hs !== ops.size() || rc !== ops.size()) begin errors++; $display("FAIL %s_hs d%0d got %0d/%0d want %0d", nm, d, hs, rc, ops.size()); end
    ack(d, v);
    checks++; if (v !== 1'b0 || busy[d] !== 1'b0) begin errors++; $display("FAIL %s_ack d%0d got valid %b busy %b want 0 0", nm, d, v, busy[d]); end
  endtask

  task automatic test_basic;
    for (int d = 0; d < 2; d++) begin
      ops = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
      test_vector(d, "three_ones", 32'h40400000);
      ops = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
      test_vector(d, "four_ones", 32'h40800000);
      checks++;
      if ({add_in1[d], add_in2[d], add_in3[d]} !== {32'h3F800000, 64'h0}) begin
        errors++; $display("FAIL four_ones_pad_lanes d%0d got %h %h %h want 3f800000 0 0", d, add_in1[d], add_in2[d], add_in3[d]);
      end
      ops = '{32'h40000000, 32'hBF000000};
      test_vector(d, "mixed_sign", 32'h3FC00000);
    end
  endtask

  task automatic test_len_zero;
    logic [31:0] res; int lat, hs, rc; bit to, stable; logic v;
    ops = {};
    do_run(0, 0, 1'b0, res, lat, hs, rc, to);
    checks++; if (to || lat !== 1) begin errors++; $display("FAIL len0_lat got %0d want 1", lat); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL len0_res got %h want 0", res); end
    checks++; if (rc !== 0) begin errors++; $display("FAIL len0_in_ready got %0d cycles want 0", rc); end
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      start[0] = (k == 2); len[0] = 16'd3;
      @(posedge clk); #1;
      if (res_valid[0] !== 1'b1 || res_data[0] !== 32'h0 || in_ready[0] !== 1'b0) stable = 1'b0;
    end
    start[0] = 1'b0;
    checks++; if (!stable) begin errors++; $display("FAIL len0_hold got valid %b data %h want 1 0", res_valid[0], res_data[0]); end
    ack(0, v);
    checks++; if (v !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL len0_ack got valid %b busy %b want 0 0", v, busy[0]); end
  endtask

  task automatic test_stall;
    logic [31:0] res; int lat, hs, rc; bit to; logic v;
    for (int d = 0; d < 2; d++) begin
      ops = {};
      for (int i = 0; i < 6; i++) ops.push_back(32'h3F800000);
      do_run(d, 6, 1'b1, res, lat, hs, rc, to);
      checks++; if (to || res !== 32'h40C00000) begin errors++; $display("FAIL stall_res d%0d got %h want 40c00000", d, res); end
      checks++; if (hs !== 6) begin errors++; $display("FAIL stall_hs d%0d got %0d want 6", d, hs); end
      checks++; if (rc !== 10) begin errors++; $display("FAIL stall_in_ready d%0d got %0d cycles want 10", d, rc); end
      ack(d, v);
    end
  endtask

  task automatic test_random;
    logic [31:0] res; int lat, hs, rc, n, v; bit to; real sum; logic va;
    for (int it = 0; it < 12; it++) begin
      int d;
      d = it % 2;
      n = $urandom_range(1, 13);
      ops = {}; sum = 0.0;
      for (int i = 0; i < n; i++) begin
        v = $urandom_range(1, 100);
        sum += real'(v);
        ops.push_back(f_enc(real'(v)));
      end
      do_run(d, n, 1'b0, res, lat, hs, rc, to);
      checks++; if (to || res !== f_enc(sum)) begin errors++; $display("FAIL rand_res it%0d n%0d got %h want %h", it, n, res, f_enc(sum)); end
      checks++; if (lat !== exp_lat(d, n) || hs !== n) begin errors++; $display("FAIL rand_timing it%0d got lat %0d hs %0d want %0d %0d", it, lat, hs, exp_lat(d, n), n); end
      ack(d, va);
    end
  endtask

  task automatic test_mid_reset;
    int idx, lat;
    start[1] = 1'b1; len[1] = 16'd6;
    @(posedge clk); #1;
    start[1] = 1'b0; idx = 0; lat = 1;
    while (lat < 11) begin
      in_valid[1] = (idx < 6); in_data[1] = 32'h3F800000;
      if (in_ready[1] && in_valid[1]) idx++;
      @(posedge clk); #1;
      lat++;
    end
    in_valid[1] = 1'b0;
    checks++; if (busy[1] !== 1'b1 || in_ready[1] !== 1'b0) begin errors++; $display("FAIL midrst_in_add got busy %b in_ready %b want 1 0", busy[1], in_ready[1]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy[1], in_ready[1], res_valid[1]} !== 3'b0 || res_data[1] !== 32'h0 ||
        {add_in0[1], add_in1[1], add_in2[1], add_in3[1]} !== 128'h0) begin
      errors++; $display("FAIL midrst_outputs got busy %b add_in0 %h add_in1 %h want all 0", busy[1], add_in0[1], add_in1[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ops = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
    test_vector(1, "after_reset", 32'h40400000);
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0; in_valid = '0; res_ready = '0; len = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_len_zero;
    test_stall;
    test_random;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
